// File: rtl/rx_lkp_pkg.sv
// rx_lkp_pkg: shared state encoding and request field layout for the RX lookup arbiter
package rx_lkp_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } lkp_state_t;
    localparam int INFO_W   = 108;
    localparam int DMAC_LSB = 0;
    localparam int SMAC_LSB = 48;
    localparam int VID_LSB  = 96;
    localparam int MAC_W    = 48;
    localparam int VID_W    = 12;
endpackage

// File: rtl/rx_lkp_req_arb_rr_prio_sel.sv
// rr_prio_sel: combinational round-robin picker, first set request at or above ptr with wrap
module rr_prio_sel #(
    parameter int N  = 8,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);
    // Scan downward in distance from ptr so the nearest request is the last to win.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N]) idx = PW'((int'(ptr) + i) % N);
        grant = '0;
        grant[idx] = |req;
    end
endmodule

// File: rtl/rx_lkp_req_arb.sv
// rx_lkp_req_arb: round-robin sharing of the MAC/VLAN lookup engine between RX ports
module rx_lkp_req_arb
    import rx_lkp_pkg::*;
#(
    parameter int PORT_NUM    = 8,
    parameter int INFO_W      = rx_lkp_pkg::INFO_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [PORT_NUM-1:0]        i_req_vld,
    input  logic [PORT_NUM*INFO_W-1:0] i_req_info,
    output logic [PORT_NUM-1:0]        o_req_ack,
    output logic                       o_lkp_vld,
    input  logic                       i_lkp_ready,
    output logic [MAC_W-1:0]           o_lkp_dmac,
    output logic [MAC_W-1:0]           o_lkp_smac,
    output logic [VID_W-1:0]           o_lkp_vlan_id,
    output logic [PORT_NUM-1:0]        o_lkp_port,
    input  logic                       i_lkp_done,
    output logic                       o_busy,
    output logic                       o_timeout
);
    localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    lkp_state_t          state;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       idx;
    logic [PORT_NUM-1:0] grant;
    logic [7:0]          cnt;
    logic [7:0]          cnt_nxt;
    logic [INFO_W-1:0]   info;

    rr_prio_sel #(.N(PORT_NUM), .PW(PW)) u_sel (
        .req   (i_req_vld),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (idx)
    );

    // cnt_nxt counts WAIT_DONE cycles including the current one, so the abort
    // lands exactly TIMEOUT_CYC cycles after the handshake.
    always_comb begin
        cnt_nxt = cnt + 8'd1;
        info    = i_req_info[int'(idx) * INFO_W +: INFO_W];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cnt           <= '0;
            o_req_ack     <= '0;
            o_lkp_vld     <= 1'b0;
            o_lkp_dmac    <= '0;
            o_lkp_smac    <= '0;
            o_lkp_vlan_id <= '0;
            o_lkp_port    <= '0;
            o_busy        <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            o_req_ack <= '0;
            o_timeout <= 1'b0;
            case (state)
                IDLE: if (|i_req_vld) begin
                    state         <= ISSUE;
                    o_req_ack     <= grant;
                    o_lkp_port    <= grant;
                    o_lkp_vld     <= 1'b1;
                    o_busy        <= 1'b1;
                    o_lkp_dmac    <= info[DMAC_LSB +: MAC_W];
                    o_lkp_smac    <= info[SMAC_LSB +: MAC_W];
                    o_lkp_vlan_id <= info[VID_LSB +: VID_W];
                    rr_ptr        <= (int'(idx) == PORT_NUM - 1) ? '0 : idx + 1'b1;
                end
                ISSUE: if (i_lkp_ready) begin
                    state     <= WAIT_DONE;
                    o_lkp_vld <= 1'b0;
                    cnt       <= '0;
                end
                WAIT_DONE: begin
                    cnt <= cnt_nxt;
                    if (i_lkp_done || cnt_nxt == 8'(TIMEOUT_CYC - 1)) begin
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                        o_timeout <= !i_lkp_done;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_lkp_req_arb.sv
// tb_rx_lkp_req_arb: randomized scoreboard bench for the RX lookup request arbiter
module tb_rx_lkp_req_arb;
    localparam int N = 8;
    localparam int W = 108;
    localparam int T = 16;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b0;
    logic [N-1:0]   i_req_vld = '0;
    logic [N*W-1:0] i_req_info = '0;
    logic [N-1:0]   o_req_ack;
    logic           o_lkp_vld;
    logic           i_lkp_ready = 1'b0;
    logic [47:0]    o_lkp_dmac;
    logic [47:0]    o_lkp_smac;
    logic [11:0]    o_lkp_vlan_id;
    logic [N-1:0]   o_lkp_port;
    logic           i_lkp_done = 1'b0;
    logic           o_busy;
    logic           o_timeout;

    rx_lkp_req_arb #(.PORT_NUM(N), .INFO_W(W), .TIMEOUT_CYC(T)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_vld     (i_req_vld),
        .i_req_info    (i_req_info),
        .o_req_ack     (o_req_ack),
        .o_lkp_vld     (o_lkp_vld),
        .i_lkp_ready   (i_lkp_ready),
        .o_lkp_dmac    (o_lkp_dmac),
        .o_lkp_smac    (o_lkp_smac),
        .o_lkp_vlan_id (o_lkp_vlan_id),
        .o_lkp_port    (o_lkp_port),
        .i_lkp_done    (i_lkp_done),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference model: pending set per port, round-robin pointer, expected event queues.
    logic [N-1:0] pend = '0;
    logic [W-1:0] info_m [N];
    int           rr = 0;
    int           exp_port [$];
    logic [W-1:0] exp_info [$];
    int           to_q [$];
    logic         exp_busy = 1'b0;
    logic         exp_vld = 1'b0;
    logic         started = 1'b0;
    logic [W-1:0] held;
    int           mon_g;
    logic [W-1:0] mon_inf;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rnd_info();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    function automatic int pick();
        for (int i = 0; i < N; i++)
            if (pend[(rr + i) % N]) return (rr + i) % N;
        return -1;
    endfunction

    task automatic add_req(input int p, input logic [W-1:0] inf);
        pend[p] = 1'b1;
        info_m[p] = inf;
        i_req_vld[p] = 1'b1;
        i_req_info[p*W +: W] = inf;
    endtask

    always @(negedge i_clk) begin
        if (started && i_rst) begin
            chk("lkp_vld", o_lkp_vld, exp_vld);
            chk("busy", o_busy, exp_busy);
            if (o_req_ack != '0) begin
                if (exp_port.size() == 0) chk("unexpected_ack", o_req_ack, 0);
                else begin
                    mon_g = exp_port.pop_front();
                    mon_inf = exp_info.pop_front();
                    chk("req_ack", o_req_ack, N'(1) << mon_g);
                    chk("lkp_port", o_lkp_port, N'(1) << mon_g);
                    chk("lkp_fields", {o_lkp_vlan_id, o_lkp_smac, o_lkp_dmac}, mon_inf);
                    held = mon_inf;
                end
            end else if (o_lkp_vld) chk("held_fields", {o_lkp_vlan_id, o_lkp_smac, o_lkp_dmac}, held);
            if (o_timeout) begin
                if (to_q.size() == 0) chk("unexpected_timeout", o_timeout, 0);
                else chk("timeout_cycle", cyc, to_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        i_rst = 1'b0;
        i_lkp_ready = 1'b0;
        i_lkp_done = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        rr = 0;
        exp_busy = 1'b0;
        exp_vld = 1'b0;
        @(negedge i_clk);
        chk("rst_ack", o_req_ack, 0);
        chk("rst_vld", o_lkp_vld, 0);
        chk("rst_dmac", o_lkp_dmac, 0);
        chk("rst_smac", o_lkp_smac, 0);
        chk("rst_vid", o_lkp_vlan_id, 0);
        chk("rst_port", o_lkp_port, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_timeout", o_timeout, 0);
    endtask

    // One grant: ddly >= T lets the timeout fire; do_rst resets somewhere in WAIT_DONE.
    task automatic txn(input int rdly, input int ddly, input bit do_rst);
        int g;
        int h;
        g = pick();
        if (g < 0) return;
        exp_port.push_back(g);
        exp_info.push_back(info_m[g]);
        rr = (g + 1) % N;
        @(posedge i_clk); #1;
        i_lkp_done = 1'b0;
        pend[g] = 1'b0;
        i_req_vld[g] = 1'b0;
        exp_busy = 1'b1;
        exp_vld = 1'b1;
        repeat (rdly) begin
            i_lkp_done = 1'($urandom_range(0, 1));
            @(posedge i_clk); #1;
        end
        i_lkp_done = 1'b0;
        i_lkp_ready = 1'b1;
        h = cyc;
        @(posedge i_clk); #1;
        i_lkp_ready = 1'b0;
        exp_vld = 1'b0;
        if (do_rst) begin
            repeat ($urandom_range(0, T - 3)) begin @(posedge i_clk); #1; end
            do_reset();
            return;
        end
        if (ddly >= T) begin
            repeat (T - 1) begin @(posedge i_clk); #1; end
            to_q.push_back(h + T);
            exp_busy = 1'b0;
            i_lkp_done = 1'b1;
        end else begin
            repeat (ddly - 1) begin @(posedge i_clk); #1; end
            i_lkp_done = 1'b1;
            @(posedge i_clk); #1;
            i_lkp_done = 1'b0;
            exp_busy = 1'b0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        started = 1'b1;
        for (int p = 0; p < N; p++) add_req(p, rnd_info());
        for (int i = 0; i < N + 1; i++) begin
            txn(0, 1, 0);
            if (i < N) for (int p = 0; p < N; p++) if (!pend[p]) add_req(p, rnd_info());
        end
        for (int i = 0; i < N - 1; i++) txn(0, 1, 0);
        add_req(3, {12'h064, 48'h6677_8899_AABB, 48'h0011_2233_4455});
        txn(0, 2, 0);
        add_req(5, rnd_info());
        txn(1, 1, 0);
        add_req(1, rnd_info());
        add_req(6, rnd_info());
        txn(0, 1, 0);
        txn(0, 3, 0);
        add_req(2, rnd_info());
        add_req(5, rnd_info());
        txn(10, 1, 0);
        txn(0, 1, 0);
        add_req(0, rnd_info());
        txn(0, T, 0);
        add_req(4, rnd_info());
        txn(2, T - 1, 0);
        add_req(7, rnd_info());
        txn(0, 5, 1);
        add_req(2, rnd_info());
        add_req(5, rnd_info());
        txn(0, 1, 0);
        txn(0, 1, 0);
        for (int i = 0; i < 200; i++) begin
            for (int p = 0; p < N; p++) if (!pend[p] && $urandom_range(0, 2) == 0) add_req(p, rnd_info());
            if (pend == '0) add_req($urandom_range(0, N - 1), rnd_info());
            txn($urandom_range(0, 3), $urandom_range(1, T), $urandom_range(0, 30) == 0);
        end
        pend = '0;
        i_req_vld = '0;
        i_lkp_done = 1'b0;
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        chk("ack_queue_empty", exp_port.size(), 0);
        chk("timeout_queue_empty", to_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
